sram_access_ctrl: RTL and testbench

- Downstream of the SNES address decoder; sole owner of the external 16-bit cartridge SRAM bus.
- Consumes the decoder's mapped address, hit and writable flags, plus synchronized SNES read/write start pulses.
- Runs timed SRAM read/write cycles and arbitrates the MCU port into idle bus slots. SNES always has priority.

---
 rtl/sram_pkg.sv | 37 +++
 rtl/sram_req_latch.sv | 50 +++++
 rtl/sram_access_ctrl.sv | 208 ++++++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/sram_pkg.sv
// Shared types and helpers for the cartridge SRAM access controller.
// State encoding, byte-lane selection and cycle-count legality checks.
package sram_pkg;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    StIdle,
    StSnesRd,
    StSnesWr,
    StMcuRd,
    StMcuWr,
    StRecover
  } state_e;

  typedef struct packed {
    logic bhe_n;
    logic ble_n;
  } lane_t;

  // Odd byte addresses live on the low lane, even ones on the high lane.
  function automatic lane_t lane_sel(input logic a0);
    lane_t l;
    l.bhe_n = a0;
    l.ble_n = ~a0;
    return l;
  endfunction

  function automatic logic [7:0] lane_byte(input logic [15:0] dq, input logic a0);
    return a0 ? dq[7:0] : dq[15:8];
  endfunction

  function automatic bit cycles_legal(input int unsigned n);
    return (n >= 2) && (n <= 15);
  endfunction

endpackage

// File: rtl/sram_req_latch.sv
// Pending-request holder: captures type/address/data on a pulse, cleared on service.
// Outputs present the request as it will be seen after this cycle's capture.
module sram_req_latch
  import sram_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cap,
  input  logic        cap_wr,
  input  logic [23:0] cap_addr,
  input  logic [7:0]  cap_data,
  input  logic        clr,
  output logic        pend,
  output logic        wr,
  output logic [23:0] addr,
  output logic [7:0]  data
);

  logic        pend_q;
  logic        wr_q;
  logic [23:0] addr_q;
  logic [7:0]  data_q;

  // Look-through lets an idle controller start service the cycle after the pulse.
  assign pend = cap | pend_q;
  assign wr   = cap ? cap_wr   : wr_q;
  assign addr = cap ? cap_addr : addr_q;
  assign data = cap ? cap_data : data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      if (cap) begin
        wr_q   <= cap_wr;
        addr_q <= cap_addr;
        data_q <= cap_data;
      end
      if (clr) begin
        pend_q <= 1'b0;
      end else if (cap) begin
        pend_q <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/sram_access_ctrl.sv
// Owner of the 16-bit cartridge SRAM bus: timed SNES/MCU accesses, SNES has priority.
// Optional MCU stall counter enabled by defining SRAM_MCU_STALL_CNT_EN.
module sram_access_ctrl
  import sram_pkg::*;
#(
  parameter int unsigned RD_CYCLES = 4,
  parameter int unsigned WR_CYCLES = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        SNES_RD_START,
  input  logic        SNES_WR_START,
  input  logic [23:0] ROM_ADDR,
  input  logic        ROM_HIT,
  input  logic        IS_WRITABLE,
  input  logic [7:0]  SNES_DATA_IN,
  output logic [7:0]  SNES_DATA_OUT,
  input  logic        MCU_RRQ,
  input  logic        MCU_WRQ,
  input  logic [23:0] MCU_ADDR,
  input  logic [7:0]  MCU_DOUT,
  output logic [7:0]  MCU_DIN,
  output logic        MCU_RDY,
  output logic [22:0] SRAM_A,
  output logic [15:0] SRAM_DQ_OUT,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_IN,
  output logic        SRAM_OEn,
  output logic        SRAM_WEn,
  output logic        SRAM_BHEn,
  output logic        SRAM_BLEn
`ifdef SRAM_MCU_STALL_CNT_EN
  ,
  input  logic        MCU_STALL_CLR,
  output logic [15:0] MCU_STALL_CNT
`endif
);

  if (!cycles_legal(RD_CYCLES) || !cycles_legal(WR_CYCLES)) begin : g_bad_cycles
    $error("RD_CYCLES and WR_CYCLES must be in 2..15");
  end

  localparam logic [CNT_W-1:0] RdLast = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WrLast = CNT_W'(WR_CYCLES);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [22:0]      sram_a_q;
  logic [15:0]      dq_out_q;
  logic             dq_oe_q, oe_n_q, we_n_q, bhe_n_q, ble_n_q;
  logic [7:0]       snes_dout_q, mcu_din_q;
  logic             mcu_rdy_q;

  logic        snes_rd_ok, snes_wr_ok, snes_cap, mcu_cap;
  logic        snes_pend, snes_wr, mcu_pend, mcu_wr;
  logic [23:0] snes_addr, mcu_addr;
  logic [7:0]  snes_data, mcu_data;
  logic        go, go_snes, sel_wr, snes_clr, mcu_clr, mcu_done;
  logic [23:0] sel_addr;
  logic [7:0]  sel_data;

  // Unmapped or read-only targets are dropped here and never reach the bus.
  assign snes_rd_ok = SNES_RD_START & ROM_HIT;
  assign snes_wr_ok = SNES_WR_START & ROM_HIT & IS_WRITABLE;
  assign snes_cap   = snes_rd_ok | snes_wr_ok;
  assign mcu_cap    = (MCU_RRQ | MCU_WRQ) & mcu_rdy_q;

  sram_req_latch u_snes_req (
    .clk      (CLK),
    .rst      (RST),
    .cap      (snes_cap),
    .cap_wr   (snes_wr_ok),
    .cap_addr (ROM_ADDR),
    .cap_data (SNES_DATA_IN),
    .clr      (snes_clr),
    .pend     (snes_pend),
    .wr       (snes_wr),
    .addr     (snes_addr),
    .data     (snes_data)
  );

  sram_req_latch u_mcu_req (
    .clk      (CLK),
    .rst      (RST),
    .cap      (mcu_cap),
    .cap_wr   (MCU_WRQ),
    .cap_addr (MCU_ADDR),
    .cap_data (MCU_DOUT),
    .clr      (mcu_clr),
    .pend     (mcu_pend),
    .wr       (mcu_wr),
    .addr     (mcu_addr),
    .data     (mcu_data)
  );

  always_comb begin
    go       = ((state_q == StIdle) || (state_q == StRecover)) && (snes_pend || mcu_pend);
    go_snes  = snes_pend;
    sel_wr   = snes_pend ? snes_wr   : mcu_wr;
    sel_addr = snes_pend ? snes_addr : mcu_addr;
    sel_data = snes_pend ? snes_data : mcu_data;
    snes_clr = go && snes_pend;
    mcu_clr  = go && !snes_pend;
    mcu_done = ((state_q == StMcuRd) && (cnt_q == RdLast)) ||
               ((state_q == StMcuWr) && (cnt_q == WrLast));
  end

  // RECOVER doubles as an arbitration slot so a waiting request starts right after it.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sram_a_q    <= '0;
      dq_out_q    <= '0;
      dq_oe_q     <= 1'b0;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      bhe_n_q     <= 1'b1;
      ble_n_q     <= 1'b1;
      snes_dout_q <= '0;
      mcu_din_q   <= '0;
    end else begin
      unique case (state_q)
        StIdle, StRecover: begin
          oe_n_q <= 1'b1;
          we_n_q <= 1'b1;
          if (go) begin
            if (go_snes) state_q <= sel_wr ? StSnesWr : StSnesRd;
            else         state_q <= sel_wr ? StMcuWr  : StMcuRd;
            cnt_q                <= '0;
            sram_a_q             <= sel_addr[23:1];
            {bhe_n_q, ble_n_q}   <= lane_sel(sel_addr[0]);
            oe_n_q               <= sel_wr;
            dq_oe_q              <= sel_wr;
            if (sel_wr) dq_out_q <= {sel_data, sel_data};
          end else begin
            state_q <= StIdle;
            dq_oe_q <= 1'b0;
            bhe_n_q <= 1'b1;
            ble_n_q <= 1'b1;
          end
        end
        StSnesRd, StMcuRd: begin
          if (cnt_q == RdLast) begin
            oe_n_q  <= 1'b1;
            state_q <= StRecover;
            if (state_q == StSnesRd) snes_dout_q <= lane_byte(SRAM_DQ_IN, ~ble_n_q);
            else                     mcu_din_q   <= lane_byte(SRAM_DQ_IN, ~ble_n_q);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        StSnesWr, StMcuWr: begin
          if (cnt_q == WrLast) begin
            we_n_q  <= 1'b1;
            state_q <= StRecover;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            we_n_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      mcu_rdy_q <= 1'b1;
    end else if (mcu_done) begin
      mcu_rdy_q <= 1'b1;
    end else if (mcu_cap) begin
      mcu_rdy_q <= 1'b0;
    end
  end

`ifdef SRAM_MCU_STALL_CNT_EN
  logic [15:0] stall_q;
  logic        stall_inc;

  assign stall_inc = !mcu_rdy_q && ((state_q == StSnesRd) || (state_q == StSnesWr) ||
                                    ((state_q == StIdle) && snes_pend));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      stall_q <= '0;
    end else if (MCU_STALL_CLR) begin
      stall_q <= '0;
    end else if (stall_inc && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign MCU_STALL_CNT = stall_q;
`endif

  assign SNES_DATA_OUT = snes_dout_q;
  assign MCU_DIN       = mcu_din_q;
  assign MCU_RDY       = mcu_rdy_q;
  assign SRAM_A        = sram_a_q;
  assign SRAM_DQ_OUT   = dq_out_q;
  assign SRAM_DQ_OE    = dq_oe_q;
  assign SRAM_OEn      = oe_n_q;
  assign SRAM_WEn      = we_n_q;
  assign SRAM_BHEn     = bhe_n_q;
  assign SRAM_BLEn     = ble_n_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: reset, SNES/MCU reads and writes, priority, abort.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_sram_access_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic        SNES_RD_START, SNES_WR_START;
  logic [23:0] ROM_ADDR;
  logic        ROM_HIT, IS_WRITABLE;
  logic [7:0]  SNES_DATA_IN, SNES_DATA_OUT;
  logic        MCU_RRQ, MCU_WRQ;
  logic [23:0] MCU_ADDR;
  logic [7:0]  MCU_DOUT, MCU_DIN;
  logic        MCU_RDY;
  logic [22:0] SRAM_A;
  logic [15:0] SRAM_DQ_OUT, SRAM_DQ_IN;
  logic        SRAM_DQ_OE, SRAM_OEn, SRAM_WEn, SRAM_BHEn, SRAM_BLEn;
`ifdef SRAM_MCU_STALL_CNT_EN
  logic        MCU_STALL_CLR;
  logic [15:0] MCU_STALL_CNT;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  sram_access_ctrl #(.RD_CYCLES(4), .WR_CYCLES(4)) dut (
    .CLK           (CLK),
    .RST           (RST),
    .SNES_RD_START (SNES_RD_START),
    .SNES_WR_START (SNES_WR_START),
    .ROM_ADDR      (ROM_ADDR),
    .ROM_HIT       (ROM_HIT),
    .IS_WRITABLE   (IS_WRITABLE),
    .SNES_DATA_IN  (SNES_DATA_IN),
    .SNES_DATA_OUT (SNES_DATA_OUT),
    .MCU_RRQ       (MCU_RRQ),
    .MCU_WRQ       (MCU_WRQ),
    .MCU_ADDR      (MCU_ADDR),
    .MCU_DOUT      (MCU_DOUT),
    .MCU_DIN       (MCU_DIN),
    .MCU_RDY       (MCU_RDY),
    .SRAM_A        (SRAM_A),
    .SRAM_DQ_OUT   (SRAM_DQ_OUT),
    .SRAM_DQ_OE    (SRAM_DQ_OE),
    .SRAM_DQ_IN    (SRAM_DQ_IN),
    .SRAM_OEn      (SRAM_OEn),
    .SRAM_WEn      (SRAM_WEn),
    .SRAM_BHEn     (SRAM_BHEn),
    .SRAM_BLEn     (SRAM_BLEn)
`ifdef SRAM_MCU_STALL_CNT_EN
    ,
    .MCU_STALL_CLR (MCU_STALL_CLR),
    .MCU_STALL_CNT (MCU_STALL_CNT)
`endif
  );

  task automatic test_reset;
    n_checks++; if (SRAM_OEn !== 1'b1) begin n_fail++; $display("FAIL reset_oen: got %b want 1", SRAM_OEn); end
    n_checks++; if (SRAM_WEn !== 1'b1) begin n_fail++; $display("FAIL reset_wen: got %b want 1", SRAM_WEn); end
    n_checks++; if ({SRAM_BHEn, SRAM_BLEn} !== 2'b11) begin n_fail++; $display("FAIL reset_lanes: got %b want 11", {SRAM_BHEn, SRAM_BLEn}); end
    n_checks++; if (SRAM_DQ_OE !== 1'b0) begin n_fail++; $display("FAIL reset_dqoe: got %b want 0", SRAM_DQ_OE); end
    n_checks++; if (SRAM_A !== 23'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", SRAM_A); end
    n_checks++; if (SRAM_DQ_OUT !== 16'h0) begin n_fail++; $display("FAIL reset_dqout: got %h want 0", SRAM_DQ_OUT); end
    n_checks++; if ({SNES_DATA_OUT, MCU_DIN} !== 16'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {SNES_DATA_OUT, MCU_DIN}); end
    n_checks++; if (MCU_RDY !== 1'b1) begin n_fail++; $display("FAIL reset_rdy: got %b want 1", MCU_RDY); end
  endtask

  task automatic test_snes_read;
    logic [8:0]  oe_mask;
    logic [22:0] a1;
    logic [1:0]  lanes1;
    logic [7:0]  d4, d5;
    oe_mask = '0; a1 = '0; lanes1 = '0; d4 = '0; d5 = '0;
    ROM_ADDR = 24'h000101; ROM_HIT = 1'b1; SRAM_DQ_IN = 16'hA55A; SNES_RD_START = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      SNES_RD_START = 1'b0;
      oe_mask[i] = ~SRAM_OEn;
      if (i == 1) begin a1 = SRAM_A; lanes1 = {SRAM_BHEn, SRAM_BLEn}; end
      if (i == 4) d4 = SNES_DATA_OUT;
      if (i == 5) d5 = SNES_DATA_OUT;
    end
    n_checks++; if (oe_mask !== 9'h01E) begin n_fail++; $display("FAIL rd_oen_window: got %h want 01e", oe_mask); end
    n_checks++; if (a1 !== 23'h000080) begin n_fail++; $display("FAIL rd_addr: got %h want 000080", a1); end
    n_checks++; if (lanes1 !== 2'b10) begin n_fail++; $display("FAIL rd_lanes: got %b want 10", lanes1); end
    n_checks++; if (d4 !== 8'h00) begin n_fail++; $display("FAIL rd_data_early: got %h want 00", d4); end
    n_checks++; if (d5 !== 8'h5A) begin n_fail++; $display("FAIL rd_data: got %h want 5a", d5); end
  endtask

  task automatic test_snes_write;
    logic [8:0]  we_mask, oe_mask;
    logic [15:0] dq1;
    logic [1:0]  lanes1;
    logic [22:0] a1;
    we_mask = '0; oe_mask = '0; dq1 = '0; lanes1 = '0; a1 = '0;
    ROM_ADDR = 24'hE00000; ROM_HIT = 1'b1; IS_WRITABLE = 1'b1; SNES_DATA_IN = 8'h3C;
    SNES_WR_START = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      @(negedge CLK);
      SNES_WR_START = 1'b0;
      we_mask[i] = ~SRAM_WEn;
      oe_mask[i] = SRAM_DQ_OE;
      if (i == 1) begin dq1 = SRAM_DQ_OUT; lanes1 = {SRAM_BHEn, SRAM_BLEn}; a1 = SRAM_A; end
    end
    n_checks++; if (we_mask !== 9'h03C) begin n_fail++; $display("FAIL wr_wen_window: got %h want 03c", we_mask); end
    n_checks++; if (oe_mask !== 9'h07E) begin n_fail++; $display("FAIL wr_dqoe_window: got %h want 07e", oe_mask); end
    n_checks++; if (dq1 !== 16'h3C3C) begin n_fail++; $display("FAIL wr_dqout: got %h want 3c3c", dq1); end
    n_checks++; if (lanes1 !== 2'b01) begin n_fail++; $display("FAIL wr_lanes: got %b want 01", lanes1); end
    n_checks++; if (a1 !== 23'h700000) begin n_fail++; $display("FAIL wr_addr: got %h want 700000", a1); end
  endtask

  task automatic test_discard;
    logic [6:0] act_mask;
    act_mask = '0;
    ROM_ADDR = 24'h000010; ROM_HIT = 1'b1; IS_WRITABLE = 1'b0; SNES_DATA_IN = 8'h77;
    SNES_WR_START = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge CLK);
      SNES_WR_START = 1'b0;
      if (i == 2) begin ROM_HIT = 1'b0; IS_WRITABLE = 1'b1; SNES_RD_START = 1'b1; end
      else SNES_RD_START = 1'b0;
      act_mask[i] = ~SRAM_WEn | ~SRAM_OEn | SRAM_DQ_OE | ~SRAM_BHEn | ~SRAM_BLEn;
    end
    ROM_HIT = 1'b1;
    n_checks++; if (act_mask !== 7'h00) begin n_fail++; $display("FAIL discard_no_access: got %h want 00", act_mask); end
    n_checks++; if (SNES_DATA_OUT !== 8'h5A) begin n_fail++; $display("FAIL discard_data_kept: got %h want 5a", SNES_DATA_OUT); end
  endtask

  task automatic test_priority;
    logic [12:0] oe_mask, busy_mask, we_mask;
    logic [22:0] a1, a6;
    logic [7:0]  sd5, md9, md10;
    oe_mask = '0; busy_mask = '0; we_mask = '0; a1 = '0; a6 = '0; sd5 = '0; md9 = '0; md10 = '0;
    ROM_ADDR = 24'h000202; ROM_HIT = 1'b1; MCU_ADDR = 24'h000005; SRAM_DQ_IN = 16'hC3B4;
    SNES_RD_START = 1'b1; MCU_RRQ = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      SNES_RD_START = 1'b0;
      MCU_RRQ = 1'b0;
      MCU_WRQ = (i == 3);
      oe_mask[i]   = ~SRAM_OEn;
      busy_mask[i] = ~MCU_RDY;
      we_mask[i]   = ~SRAM_WEn;
      if (i == 1) a1 = SRAM_A;
      if (i == 6) a6 = SRAM_A;
      if (i == 5) sd5 = SNES_DATA_OUT;
      if (i == 9) md9 = MCU_DIN;
      if (i == 10) md10 = MCU_DIN;
    end
    MCU_WRQ = 1'b0;
    n_checks++; if (oe_mask !== 13'h03DE) begin n_fail++; $display("FAIL prio_oen_window: got %h want 03de", oe_mask); end
    n_checks++; if (busy_mask !== 13'h03FE) begin n_fail++; $display("FAIL prio_rdy_window: got %h want 03fe", busy_mask); end
    n_checks++; if (we_mask !== 13'h0) begin n_fail++; $display("FAIL prio_busy_req_ignored: got %h want 0", we_mask); end
    n_checks++; if (a1 !== 23'h000101) begin n_fail++; $display("FAIL prio_snes_addr: got %h want 000101", a1); end
    n_checks++; if (a6 !== 23'h000002) begin n_fail++; $display("FAIL prio_mcu_addr: got %h want 000002", a6); end
    n_checks++; if (sd5 !== 8'hC3) begin n_fail++; $display("FAIL prio_snes_data: got %h want c3", sd5); end
    n_checks++; if (md9 !== 8'h00) begin n_fail++; $display("FAIL prio_mcu_data_early: got %h want 00", md9); end
    n_checks++; if (md10 !== 8'hB4) begin n_fail++; $display("FAIL prio_mcu_data: got %h want b4", md10); end
  endtask

`ifdef SRAM_MCU_STALL_CNT_EN
  task automatic test_stall_cnt;
    MCU_STALL_CLR = 1'b1;
    @(negedge CLK);
    MCU_STALL_CLR = 1'b0;
    n_checks++; if (MCU_STALL_CNT !== 16'h0) begin n_fail++; $display("FAIL stall_clear: got %h want 0", MCU_STALL_CNT); end
    ROM_ADDR = 24'h000300; ROM_HIT = 1'b1; MCU_ADDR = 24'h000400;
    SNES_RD_START = 1'b1; MCU_RRQ = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge CLK);
      SNES_RD_START = 1'b0;
      MCU_RRQ = 1'b0;
    end
    n_checks++; if (MCU_STALL_CNT !== 16'd4) begin n_fail++; $display("FAIL stall_count: got %0d want 4", MCU_STALL_CNT); end
  endtask
`endif

  task automatic test_reset_mid_access;
    logic [15:0] dq1;
    logic [4:0]  act_mask;
    dq1 = '0; act_mask = '0;
    MCU_ADDR = 24'h000011; MCU_DOUT = 8'h5A; MCU_WRQ = 1'b1;
    @(negedge CLK);
    MCU_WRQ = 1'b0;
    dq1 = SRAM_DQ_OUT;
    @(negedge CLK);
    @(negedge CLK);
    n_checks++; if (SRAM_WEn !== 1'b0) begin n_fail++; $display("FAIL abort_wen_before: got %b want 0", SRAM_WEn); end
    RST = 1'b1;
    #1;
    n_checks++; if (dq1 !== 16'h5A5A) begin n_fail++; $display("FAIL mcu_wr_dqout: got %h want 5a5a", dq1); end
    n_checks++; if (SRAM_WEn !== 1'b1) begin n_fail++; $display("FAIL abort_wen: got %b want 1", SRAM_WEn); end
    n_checks++; if (SRAM_DQ_OE !== 1'b0) begin n_fail++; $display("FAIL abort_dqoe: got %b want 0", SRAM_DQ_OE); end
    n_checks++; if (MCU_RDY !== 1'b1) begin n_fail++; $display("FAIL abort_rdy: got %b want 1", MCU_RDY); end
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      act_mask[i] = ~SRAM_WEn | ~SRAM_OEn | SRAM_DQ_OE;
    end
    n_checks++; if (act_mask !== 5'h0) begin n_fail++; $display("FAIL abort_abandoned: got %h want 0", act_mask); end
  endtask

  initial begin
    RST = 1'b1;
    SNES_RD_START = 1'b0; SNES_WR_START = 1'b0;
    ROM_ADDR = '0; ROM_HIT = 1'b0; IS_WRITABLE = 1'b0; SNES_DATA_IN = '0;
    MCU_RRQ = 1'b0; MCU_WRQ = 1'b0; MCU_ADDR = '0; MCU_DOUT = '0;
    SRAM_DQ_IN = '0;
`ifdef SRAM_MCU_STALL_CNT_EN
    MCU_STALL_CLR = 1'b0;
`endif
    repeat (3) @(negedge CLK);
    test_reset;
    RST = 1'b0;
    @(negedge CLK);
    test_snes_read;
    test_snes_write;
    test_discard;
    test_priority;
`ifdef SRAM_MCU_STALL_CNT_EN
    test_stall_cnt;
`endif
    test_reset_mid_access;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
